// File: rtl/oled_spi_pkg.sv
// Shared types and default parameters for the OLED SPI transmit controller.
//   state_e  : controller FSM states
//   entry_t  : FIFO entry {dc, data}; data is sized for the widest legal word
//              and the controller uses the low DATA_W bits.
package oled_spi_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned CLK_DIV_DEF    = 10;
    localparam int unsigned CS_HOLD_DEF    = 3;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    localparam int unsigned MAX_DATA_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  dc;
        logic [MAX_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/oled_spi_fifo.sv
// Synchronous FIFO with asynchronous reset. No write bypass: a push is refused
// while full even if a pop happens on the same edge.
//   clk_i, rst_ni : clock, async active-low reset (flushes the FIFO)
//   push_i/wdata_i: write request and entry (ignored when full)
//   pop_i/rdata_o : read request and head entry (ignored when empty)
//   full_o, empty_o, level_o : occupancy status
module oled_spi_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  entry_t                   wdata_i,
    input  logic                     pop_i,
    output entry_t                   rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/oled_spi_ctrl.sv
// SPI (mode 3, MSB first) transmit controller for the OLED panel.
// Words written through a valid/ready port are queued in a FIFO and shifted
// out with a programmable SCLK divider and nCS hold time.
// Build option: define OLED_SPI_BURST_EN to let queued words share one nCS
// low window; otherwise every word is framed individually.
//   clk_i, rst_ni              : clock, async active-low reset
//   wdata_i, wdc_i, wvalid_i   : word, D/C flag (1 = data), write request
//   wready_o                   : FIFO not full
//   level_o                    : FIFO occupancy, excluding the word in flight
//   busy_o                     : controller not idle
//   done_o                     : one-cycle pulse at the end of each word
//   nCS_o, SCLK_o, SDO_o, DC_o : registered panel interface
module oled_spi_ctrl
    import oled_spi_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned CS_HOLD    = CS_HOLD_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic                          wdc_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          nCS_o,
    output logic                          SCLK_o,
    output logic                          SDO_o,
    output logic                          DC_o
);

    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned HALF      = CLK_DIV / 2;
    localparam int unsigned PH_MAX    = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
    localparam int unsigned PH_W      = $clog2(PH_MAX);
    localparam int unsigned BC_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned SHIFT_PAD = MAX_DATA_W - DATA_W;

    state_e                state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [BC_W-1:0]       bc_q, bc_d;
    logic [MAX_DATA_W-1:0] shift_q, shift_d;
    logic                  dc_q, dc_d;
    logic                  ncs_q, ncs_d;
    logic                  sclk_q, sclk_d;
    logic                  sdo_q, sdo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    entry_t                wr_entry_c;
    entry_t                head_c;
    logic                  fifo_full_c;
    logic                  fifo_empty_c;
    logic                  pop_c;
    logic [LVL_W-1:0]      fifo_level_c;

    // Pack the incoming word into a FIFO entry.
    always_comb begin
        wr_entry_c      = '0;
        wr_entry_c.dc   = wdc_i;
        wr_entry_c.data = MAX_DATA_W'(wdata_i);
    end

    oled_spi_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wvalid_i),
        .wdata_i (wr_entry_c),
        .pop_i   (pop_c),
        .rdata_o (head_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c),
        .level_o (fifo_level_c)
    );

    assign wready_o = !fifo_full_c;
    assign level_o  = fifo_level_c;

    // Next-state, counters and next values of the registered outputs.
    // The word is left-aligned in the shift register so SDO is always its MSB.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        dc_d    = dc_q;
        pop_c   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = head_c.data << SHIFT_PAD;
                    dc_d    = head_c.dc;
                    ph_d    = '0;
                    bc_d    = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ph_q == PH_W'(CLK_DIV - 1)) begin
                    ph_d = '0;
                    if (bc_q == BC_W'(DATA_W - 1)) begin
                        done_d = 1'b1;
`ifdef OLED_SPI_BURST_EN
                        if (!fifo_empty_c) begin
                            pop_c   = 1'b1;
                            shift_d = head_c.data << SHIFT_PAD;
                            dc_d    = head_c.dc;
                            bc_d    = '0;
                        end else begin
                            state_d = ST_HOLD;
                        end
`else
                        state_d = ST_HOLD;
`endif
                    end else begin
                        bc_d    = bc_q + BC_W'(1);
                        shift_d = shift_q << 1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_HOLD: begin
                // ph doubles as the nCS hold counter.
                if (ph_q == PH_W'(CS_HOLD - 1)) begin
                    ph_d    = '0;
                    state_d = ST_IDLE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ph_d    = '0;
                bc_d    = '0;
            end
        endcase

        ncs_d  = (state_d == ST_IDLE);
        sclk_d = (state_d != ST_SHIFT) || (ph_d >= PH_W'(HALF));
        sdo_d  = (state_d != ST_SHIFT) || shift_d[MAX_DATA_W-1];
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
            dc_q    <= 1'b0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b1;
            sdo_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
            dc_q    <= dc_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign nCS_o  = ncs_q;
    assign SCLK_o = sclk_q;
    assign SDO_o  = sdo_q;
    assign DC_o   = dc_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Self-checking bench for oled_spi_ctrl: a frame-offset model predicts every
// output each cycle; directed scenarios pin frame lengths and bit streams.
module tb_oled_spi_ctrl;

    localparam int W = 8;
    localparam int D = 10;
    localparam int H = 3;
    localparam int DEPTH = 4;
    localparam int FRAME_BITS = W * D;
`ifdef OLED_SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] wdata = '0;
    logic       wdc = 1'b0;
    logic       wvalid = 1'b0;
    logic       wready, busy, done, ncs, sclk, sdo, dc;
    logic [2:0] level;

    logic [15:0] wdata16 = '0;
    logic        wdc16 = 1'b0;
    logic        wvalid16 = 1'b0;
    logic        wready16, busy16, done16, ncs16, sclk16, sdo16, dc16;
    logic [2:0]  level16;

    oled_spi_ctrl #(.DATA_W(8), .CLK_DIV(10), .CS_HOLD(3), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wdata_i(wdata), .wdc_i(wdc), .wvalid_i(wvalid),
        .wready_o(wready), .level_o(level), .busy_o(busy), .done_o(done),
        .nCS_o(ncs), .SCLK_o(sclk), .SDO_o(sdo), .DC_o(dc)
    );

    oled_spi_ctrl #(.DATA_W(16), .CLK_DIV(2), .CS_HOLD(3), .FIFO_DEPTH(4)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .wdata_i(wdata16), .wdc_i(wdc16), .wvalid_i(wvalid16),
        .wready_o(wready16), .level_o(level16), .busy_o(busy16), .done_o(done16),
        .nCS_o(ncs16), .SCLK_o(sclk16), .SDO_o(sdo16), .DC_o(dc16)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is described by the cycle offset since its word was popped.
    logic [8:0] mq[$];
    bit         m_act = 1'b0;
    int         m_off = 0;
    logic [7:0] m_word = '0;
    logic       m_dc = 1'b0;
    logic       m_done = 1'b0;

    function automatic bit will_pop();
        return (!m_act && mq.size() > 0) ||
               (BURST && m_act && m_off == FRAME_BITS - 1 && mq.size() > 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit eow, pop, push;
        logic [8:0] head;
        if (!rst_n) begin
            mq.delete();
            m_act  = 1'b0;
            m_off  = 0;
            m_dc   = 1'b0;
            m_done = 1'b0;
        end else begin
            eow  = m_act && m_off == FRAME_BITS - 1;
            pop  = will_pop();
            push = wvalid && (mq.size() < DEPTH);
            if (pop) begin
                head   = mq.pop_front();
                m_word = head[7:0];
                m_dc   = head[8];
                m_act  = 1'b1;
                m_off  = 0;
            end else if (m_act) begin
                m_off++;
                if (m_off == FRAME_BITS + H) m_act = 1'b0;
            end
            if (push) mq.push_back({wdc, wdata});
            m_done = eow;
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        logic e_ncs, e_sclk, e_sdo;
        #1;
        if (m_act && m_off < FRAME_BITS) begin
            e_ncs  = 1'b0;
            e_sclk = (m_off % D) >= D / 2;
            e_sdo  = m_word[W - 1 - m_off / D];
        end else if (m_act) begin
            e_ncs = 1'b0; e_sclk = 1'b1; e_sdo = 1'b1;
        end else begin
            e_ncs = 1'b1; e_sclk = 1'b1; e_sdo = 1'b1;
        end
        chk("nCS", 32'(ncs), 32'(e_ncs));
        chk("SCLK", 32'(sclk), 32'(e_sclk));
        chk("SDO", 32'(sdo), 32'(e_sdo));
        chk("DC", 32'(dc), 32'(m_dc));
        chk("busy", 32'(busy), 32'(m_act));
        chk("done", 32'(done), 32'(m_done));
        chk("level", 32'(level), 32'(mq.size()));
        chk("wready", 32'(wready), 32'(mq.size() < DEPTH));
    end

    // ---------------- waveform monitor (main DUT) ----------------
    int   lows[$];
    int   gaps[$];
    bit   bits[$];
    int   run = 0, hi = 0, dc_rise = -1, dcnt = 0;
    logic p_ncs = 1'b1, p_dc = 1'b0, p_sclk = 1'b1;

    always @(posedge clk) begin
        #1;
        if (!ncs) begin
            if (p_ncs && lows.size() > 0) gaps.push_back(hi);
            if (dc && !p_dc && dc_rise < 0) dc_rise = run;
            run++;
        end else begin
            if (!p_ncs) begin
                lows.push_back(run);
                run = 0;
                hi  = 0;
            end
            hi++;
        end
        if (sclk && !p_sclk) bits.push_back(sdo);
        if (done) dcnt++;
        p_ncs  = ncs;
        p_dc   = dc;
        p_sclk = sclk;
    end

    task automatic clear_mon();
        lows.delete(); gaps.delete(); bits.delete();
        run = 0; hi = 0; dc_rise = -1; dcnt = 0;
        p_ncs = ncs; p_dc = dc; p_sclk = sclk;
    endtask

    function automatic logic [31:0] bits_val(input int first, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], bits[first + i]};
        return v;
    endfunction

    // ---------------- monitor for the 16-bit instance ----------------
    int   len16[$];
    int   per16[$];
    bit   bits16[$];
    int   run16 = 0, cyc16 = 0, last_rise16 = -1;
    logic p_ncs16 = 1'b1, p_sclk16 = 1'b1;

    always @(posedge clk) begin
        #1;
        cyc16++;
        if (!ncs16) run16++;
        else if (!p_ncs16) begin
            len16.push_back(run16);
            run16 = 0;
        end
        if (sclk16 && !p_sclk16) begin
            bits16.push_back(sdo16);
            if (last_rise16 >= 0) per16.push_back(cyc16 - last_rise16);
            last_rise16 = cyc16;
        end
        p_ncs16  = ncs16;
        p_sclk16 = sclk16;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] d, input logic c);
        bit acc = 1'b0;
        wdata  = d;
        wdc    = c;
        wvalid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            acc = wready;
            @(negedge clk);
            if (acc) break;
        end
        wvalid = 1'b0;
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            idle = !m_act && mq.size() == 0;
            if (idle) break;
            @(negedge clk);
        end
        chk("drain", 32'(idle), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] fill_w[6] = '{8'h11, 8'hC3, 8'h7E, 8'h01, 8'hF0, 8'h9A};
    logic [7:0] pp_w[4]   = '{8'h12, 8'h34, 8'h56, 8'h78};

    initial begin
        int exp_nwin, exp_len, exp_rise;
        bit found;

        repeat (2) @(negedge clk);
        // Reset values
        chk("rst_ncs", 32'(ncs), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_sdo", 32'(sdo), 32'd1);
        chk("rst_dc", 32'(dc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_wready", 32'(wready), 32'd1);
        chk("rst_ncs16", 32'(ncs16), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 0xA5, data
        clear_mon();
        send(8'hA5, 1'b1);
        wait_idle();
        chk("a_nwin", 32'(lows.size()), 32'd1);
        chk("a_len", 32'(lows.size() > 0 ? lows[0] : -1), 32'd83);
        chk("a_nbits", 32'(bits.size()), 32'd8);
        chk("a_bits", bits_val(0, 8), 32'hA5);
        chk("a_done", 32'(dcnt), 32'd1);
        chk("a_dc", 32'(dc), 32'd1);
        chk("a_ncs_end", 32'(ncs), 32'd1);

        // Three back-to-back writes
        clear_mon();
        send(8'hAE, 1'b0);
        send(8'hD5, 1'b0);
        send(8'h80, 1'b1);
        wait_idle();
        exp_nwin = BURST ? 1 : 3;
        exp_len  = BURST ? 243 : 83;
        exp_rise = BURST ? 160 : 0;
        chk("b_nwin", 32'(lows.size()), 32'(exp_nwin));
        foreach (lows[i]) chk("b_len", 32'(lows[i]), 32'(exp_len));
        chk("b_ngap", 32'(gaps.size()), 32'(exp_nwin - 1));
        foreach (gaps[i]) chk("b_gap", 32'(gaps[i]), 32'd1);
        chk("b_dc_rise", 32'(dc_rise), 32'(exp_rise));
        chk("b_nbits", 32'(bits.size()), 32'd24);
        chk("b_bits", bits_val(0, 24), 32'hAED580);

        // Fill: six writes while idle
        clear_mon();
        for (int i = 0; i < 5; i++) send(fill_w[i], 1'(i));
        chk("c_level", 32'(level), 32'd4);
        chk("c_wready", 32'(wready), 32'd0);
        send(fill_w[5], 1'b1);
        wait_idle();
        chk("c_nbits", 32'(bits.size()), 32'd48);
        for (int i = 0; i < 6; i++) chk("c_word", bits_val(8 * i, 8), 32'(fill_w[i]));
        chk("c_nwin", 32'(lows.size()), 32'(BURST ? 1 : 6));
        chk("c_done", 32'(dcnt), 32'd6);

        // Reset in the middle of 0x3C (bit 3)
        send(8'h3C, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (m_act && m_off == 3 * D + 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("d_reach", 32'(found), 32'd1);
        chk("d_sclk_pre", 32'(sclk), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("d_ncs", 32'(ncs), 32'd1);
        chk("d_sclk", 32'(sclk), 32'd1);
        chk("d_sdo", 32'(sdo), 32'd1);
        chk("d_level", 32'(level), 32'd0);
        chk("d_busy", 32'(busy), 32'd0);
        wdata  = 8'hFF;
        wvalid = 1'b1;
        repeat (2) @(negedge clk);
        wvalid = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("d_level_post", 32'(level), 32'd0);
        clear_mon();
        send(8'h5A, 1'b1);
        wait_idle();
        chk("d_nbits", 32'(bits.size()), 32'd8);
        chk("d_bits", bits_val(0, 8), 32'h5A);
        chk("d_len", 32'(lows.size() > 0 ? lows[0] : -1), 32'd83);

        // Push and pop on the same edge at level 2
        clear_mon();
        send(pp_w[0], 1'b0);
        send(pp_w[1], 1'b1);
        send(pp_w[2], 1'b0);
        chk("e_level_pre", 32'(level), 32'd2);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (will_pop()) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("e_reach", 32'(found), 32'd1);
        send(pp_w[3], 1'b1);
        chk("e_level", 32'(level), 32'd2);
        wait_idle();
        chk("e_nbits", 32'(bits.size()), 32'd32);
        chk("e_bits", bits_val(0, 32), 32'h12345678);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            wvalid = ($urandom_range(3) == 0);
            wdata  = 8'($urandom);
            wdc    = 1'($urandom);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wait_idle();

        // 16-bit word, CLK_DIV = 2
        wdata16  = 16'h8001;
        wdc16    = 1'b1;
        wvalid16 = 1'b1;
        @(negedge clk);
        wvalid16 = 1'b0;
        repeat (60) @(negedge clk);
        chk("g_nwin", 32'(len16.size()), 32'd1);
        chk("g_len", 32'(len16.size() > 0 ? len16[0] : -1), 32'd35);
        chk("g_nbits", 32'(bits16.size()), 32'd16);
        begin
            logic [31:0] v = '0;
            foreach (bits16[i]) v = {v[30:0], bits16[i]};
            chk("g_bits", v, 32'h8001);
        end
        chk("g_nper", 32'(per16.size()), 32'd15);
        foreach (per16[i]) chk("g_period", 32'(per16[i]), 32'd2);
        chk("g_dc", 32'(dc16), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

endmodule
